// File: rtl/num_sink.sv
// Ingress buffer for a num_sink: generic synchronous FIFO, caller guards push/pop.
// Latency: a pushed entry is visible at the head on the edge after the push.
// Backpressure: none internally; the owner must not push when full or pop when empty.
module num_sink_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           pop_dat,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    assign pop_dat = mem[rd_ptr];
endmodule

// AXI-Stream sink: buffers beats, drains under DRAIN_EN, publishes per-packet stats.
// Latency: beat accepted at edge N is consumed at N+1 earliest; PKT_DONE follows the pop edge.
// Backpressure: AXIS_S_TREADY drops only when the FIFO is full (and during reset).
// Ports: CLK/RST_N clock and async active-low reset; AXIS_S_* upstream stream
//   (TID ignored); DRAIN_EN pop enable; CLR_ERR clears sticky errors; PKT_DONE,
//   PKT_COUNT, LAST_LEN, LAST_SUM packet stats; DEST_ERR/LEN_ERR sticky flags;
//   FIFO_LEVEL current occupancy.
module num_sink #(
    parameter int TDATAW     = 32,
    parameter int TDESTW     = 4,
    parameter int TIDW       = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int EXP_LEN    = 1,
    parameter int MY_DEST    = 1
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          AXIS_S_TVALID,
    output logic                          AXIS_S_TREADY,
    input  logic [TDATAW-1:0]             AXIS_S_TDATA,
    input  logic                          AXIS_S_TLAST,
    input  logic [TIDW-1:0]               AXIS_S_TID,
    input  logic [TDESTW-1:0]             AXIS_S_TDEST,
    input  logic                          DRAIN_EN,
    input  logic                          CLR_ERR,
    output logic                          PKT_DONE,
    output logic [15:0]                   PKT_COUNT,
    output logic [15:0]                   LAST_LEN,
    output logic [TDATAW+7:0]             LAST_SUM,
    output logic                          DEST_ERR,
    output logic                          LEN_ERR,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = TDATAW + 8;

    typedef struct packed {
        logic [TDATAW-1:0] data;
        logic              last;
        logic [TDESTW-1:0] dest;
    } beat_t;

    typedef enum logic {IDLE, ACTIVE} state_t;

    beat_t          in_beat;
    beat_t          head;
    logic [LW-1:0]  level;
    logic           push_vld;
    logic           pop_vld;
    state_t         state_q;
    state_t         state_d;
    logic [15:0]    cur_len;
    logic [SW-1:0]  cur_sum;
    logic [15:0]    base_len;
    logic [SW-1:0]  base_sum;
    logic [15:0]    len_inc;
    logic [SW-1:0]  sum_inc;
    logic           dest_bad;
    logic           len_bad;
    logic           unused_tid;

    assign unused_tid = ^AXIS_S_TID;

    // Ready comes from the registered level only; RST_N gating keeps it low in reset.
    assign AXIS_S_TREADY = RST_N && (level != LW'(FIFO_DEPTH));
    assign push_vld      = AXIS_S_TVALID && AXIS_S_TREADY;
    assign pop_vld       = DRAIN_EN && (level != '0);
    assign in_beat       = '{data: AXIS_S_TDATA, last: AXIS_S_TLAST, dest: AXIS_S_TDEST};

    num_sink_fifo #(
        .W     ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (RST_N),
        .push     (push_vld),
        .push_dat (in_beat),
        .pop      (pop_vld),
        .pop_dat  (head),
        .level    (level)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // In IDLE the packet accumulators start from zero regardless of their
    // register contents, so a fresh packet never inherits stale partials.
    always_comb begin
        state_d  = state_q;
        base_len = cur_len;
        base_sum = cur_sum;
        case (state_q)
            IDLE: begin
                base_len = '0;
                base_sum = '0;
                if (pop_vld && !head.last) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (pop_vld && head.last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign len_inc  = (base_len == 16'hFFFF) ? base_len : base_len + 16'd1;
    assign sum_inc  = base_sum + SW'(head.data);
    assign dest_bad = pop_vld && (head.dest != TDESTW'(MY_DEST));
    assign len_bad  = pop_vld && head.last && (len_inc != 16'(EXP_LEN));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur_len   <= '0;
            cur_sum   <= '0;
            LAST_LEN  <= '0;
            LAST_SUM  <= '0;
            PKT_COUNT <= '0;
            PKT_DONE  <= 1'b0;
            DEST_ERR  <= 1'b0;
            LEN_ERR   <= 1'b0;
        end else begin
            PKT_DONE <= 1'b0;
            if (pop_vld) begin
                if (head.last) begin
                    LAST_LEN  <= len_inc;
                    LAST_SUM  <= sum_inc;
                    PKT_COUNT <= PKT_COUNT + 16'd1;
                    PKT_DONE  <= 1'b1;
                    cur_len   <= '0;
                    cur_sum   <= '0;
                end else begin
                    cur_len <= len_inc;
                    cur_sum <= sum_inc;
                end
            end
            // A new error event in the clearing cycle takes priority.
            DEST_ERR <= dest_bad || (DEST_ERR && !CLR_ERR);
            LEN_ERR  <= len_bad  || (LEN_ERR  && !CLR_ERR);
        end
    end

    assign FIFO_LEVEL = level;
endmodule

// File: tb/tb_num_sink.sv
module tb_num_sink;
    localparam int DEPTH   = 4;
    localparam int EXP_LEN = 1;
    localparam int MY_DEST = 1;

    logic        CLK;
    logic        RST_N;
    logic        tvalid;
    logic        TREADY;
    logic [31:0] tdata;
    logic        tlast;
    logic [1:0]  tid;
    logic [3:0]  tdest;
    logic        drain_en;
    logic        clr_err;
    logic        PKT_DONE;
    logic [15:0] PKT_COUNT;
    logic [15:0] LAST_LEN;
    logic [39:0] LAST_SUM;
    logic        DEST_ERR;
    logic        LEN_ERR;
    logic [2:0]  FIFO_LEVEL;

    int n_checks;
    int n_pass;

    num_sink #(
        .TDATAW(32), .TDESTW(4), .TIDW(2), .FIFO_DEPTH(DEPTH),
        .EXP_LEN(EXP_LEN), .MY_DEST(MY_DEST)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .AXIS_S_TVALID(tvalid), .AXIS_S_TREADY(TREADY), .AXIS_S_TDATA(tdata),
        .AXIS_S_TLAST(tlast), .AXIS_S_TID(tid), .AXIS_S_TDEST(tdest),
        .DRAIN_EN(drain_en), .CLR_ERR(clr_err),
        .PKT_DONE(PKT_DONE), .PKT_COUNT(PKT_COUNT), .LAST_LEN(LAST_LEN),
        .LAST_SUM(LAST_SUM), .DEST_ERR(DEST_ERR), .LEN_ERR(LEN_ERR),
        .FIFO_LEVEL(FIFO_LEVEL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: a queue of buffered beats and a list of the current
    // packet's data words; packet stats are computed from that list on completion.
    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic [3:0]  t;
    } beat_t;

    beat_t       m_q[$];
    logic [31:0] m_pkt[$];
    logic [15:0] m_count;
    logic [15:0] m_last_len;
    logic [39:0] m_last_sum;
    logic        m_done;
    logic        m_derr;
    logic        m_lerr;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_q.delete();
            m_pkt.delete();
            m_count = 0; m_last_len = 0; m_last_sum = 0;
            m_done = 0; m_derr = 0; m_lerr = 0;
        end else begin
            bit     do_pop;
            bit     do_push;
            beat_t  b;
            longint s;
            int     n;
            do_pop  = drain_en && (m_q.size() != 0);
            do_push = tvalid && (m_q.size() != DEPTH);
            m_done  = 0;
            if (clr_err) begin m_derr = 0; m_lerr = 0; end
            if (do_pop) begin
                b = m_q.pop_front();
                if (b.t != MY_DEST) m_derr = 1;
                m_pkt.push_back(b.d);
                if (b.l) begin
                    s = 0;
                    foreach (m_pkt[i]) s += m_pkt[i];
                    n = m_pkt.size();
                    m_last_len = (n > 65535) ? 16'hFFFF : n[15:0];
                    m_last_sum = s[39:0];
                    m_count    = m_count + 16'd1;
                    m_done     = 1;
                    if (m_last_len != EXP_LEN) m_lerr = 1;
                    m_pkt.delete();
                end
            end
            if (do_push) begin
                b.d = tdata; b.l = tlast; b.t = tdest;
                m_q.push_back(b);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l, input logic [3:0] t);
        logic acc;
        acc = 1'b0;
        tvalid = 1'b1; tdata = d; tlast = l; tdest = t;
        for (int i = 0; i < 50; i++) begin
            acc = TREADY;
            tick();
            if (acc) break;
        end
        tvalid = 1'b0;
        n_checks++;
        if (acc !== 1'b1) $display("FAIL send_timeout: accepted=%0b required 1", acc);
        else n_pass++;
    endtask

    task automatic wait_done(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (PKT_DONE === 1'b1) begin seen = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        tick(); tick();
        n_checks++; if (TREADY !== 1'b0) $display("FAIL rst_tready: got %0b want 0", TREADY); else n_pass++;
        n_checks++; if (FIFO_LEVEL !== 3'd0) $display("FAIL rst_level: got %0d want 0", FIFO_LEVEL); else n_pass++;
        n_checks++;
        if ({PKT_DONE, PKT_COUNT, LAST_LEN, LAST_SUM, DEST_ERR, LEN_ERR} !== '0)
            $display("FAIL rst_outputs: got done=%0b cnt=%0d len=%0d sum=%0h derr=%0b lerr=%0b want all 0",
                     PKT_DONE, PKT_COUNT, LAST_LEN, LAST_SUM, DEST_ERR, LEN_ERR);
        else n_pass++;
        RST_N = 1'b1;
        tick();
        n_checks++; if (TREADY !== 1'b1) $display("FAIL rst_release_tready: got %0b want 1", TREADY); else n_pass++;
    endtask

    task automatic test_single();
        drain_en = 1'b1;
        tvalid = 1'b1; tdata = 32'h5A; tlast = 1'b1; tdest = 4'd1;
        tick();
        tvalid = 1'b0;
        n_checks++; if (PKT_DONE !== 1'b0) $display("FAIL t1_done_early: got %0b want 0", PKT_DONE); else n_pass++;
        n_checks++; if (FIFO_LEVEL !== 3'd1) $display("FAIL t1_level: got %0d want 1", FIFO_LEVEL); else n_pass++;
        tick();
        n_checks++; if (PKT_DONE !== 1'b1) $display("FAIL t1_done: got %0b want 1", PKT_DONE); else n_pass++;
        n_checks++; if (PKT_COUNT !== 16'd1) $display("FAIL t1_count: got %0d want 1", PKT_COUNT); else n_pass++;
        n_checks++; if (LAST_LEN !== 16'd1) $display("FAIL t1_len: got %0d want 1", LAST_LEN); else n_pass++;
        n_checks++; if (LAST_SUM !== 40'h5A) $display("FAIL t1_sum: got %0h want 5a", LAST_SUM); else n_pass++;
        n_checks++; if ({DEST_ERR, LEN_ERR} !== 2'b00) $display("FAIL t1_errs: got %b want 00", {DEST_ERR, LEN_ERR}); else n_pass++;
        tick();
        n_checks++; if (PKT_DONE !== 1'b0) $display("FAIL t1_done_pulse: got %0b want 0", PKT_DONE); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] sent[6];
        int k;
        int got;
        logic acc;
        for (int i = 0; i < 6; i++) sent[i] = 32'd100 + 32'(i * 7);
        k = 0; got = 0;
        drain_en = 1'b0; tlast = 1'b1; tdest = 4'd1;
        for (int c = 0; c < 8; c++) begin
            tvalid = (k < 6);
            if (k < 6) tdata = sent[k];
            acc = tvalid && TREADY;
            tick();
            if (acc) k++;
        end
        n_checks++; if (k !== 4) $display("FAIL t2_accepted: got %0d want 4", k); else n_pass++;
        n_checks++; if (TREADY !== 1'b0) $display("FAIL t2_tready_full: got %0b want 0", TREADY); else n_pass++;
        n_checks++; if (FIFO_LEVEL !== 3'd4) $display("FAIL t2_level_full: got %0d want 4", FIFO_LEVEL); else n_pass++;
        drain_en = 1'b1;
        for (int c = 0; c < 40 && got < 6; c++) begin
            tvalid = (k < 6);
            if (k < 6) tdata = sent[k];
            acc = tvalid && TREADY;
            tick();
            if (acc) k++;
            if (PKT_DONE === 1'b1) begin
                n_checks++;
                if (LAST_SUM !== {8'd0, sent[got]})
                    $display("FAIL t2_order[%0d]: got %0d want %0d", got, LAST_SUM, sent[got]);
                else n_pass++;
                got++;
            end
        end
        tvalid = 1'b0;
        n_checks++; if (got !== 6) $display("FAIL t2_drained: got %0d packets want 6", got); else n_pass++;
    endtask

    task automatic test_len_err();
        logic seen;
        drain_en = 1'b1;
        send_beat(32'd1, 1'b0, 4'd1);
        send_beat(32'd2, 1'b0, 4'd1);
        send_beat(32'd3, 1'b1, 4'd1);
        wait_done(seen);
        n_checks++; if (seen !== 1'b1) $display("FAIL t3_done_timeout: got %0b want 1", seen); else n_pass++;
        n_checks++; if (LAST_LEN !== 16'd3) $display("FAIL t3_len: got %0d want 3", LAST_LEN); else n_pass++;
        n_checks++; if (LAST_SUM !== 40'd6) $display("FAIL t3_sum: got %0d want 6", LAST_SUM); else n_pass++;
        n_checks++; if (PKT_COUNT !== 16'd8) $display("FAIL t3_count: got %0d want 8", PKT_COUNT); else n_pass++;
        n_checks++; if (LEN_ERR !== 1'b1) $display("FAIL t3_len_err: got %0b want 1", LEN_ERR); else n_pass++;
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        n_checks++; if (LEN_ERR !== 1'b0) $display("FAIL t3_len_err_clr: got %0b want 0", LEN_ERR); else n_pass++;
    endtask

    task automatic test_dest_err();
        logic seen;
        drain_en = 1'b1;
        send_beat(32'd7, 1'b1, 4'd2);
        wait_done(seen);
        n_checks++; if (seen !== 1'b1) $display("FAIL t4_done_timeout: got %0b want 1", seen); else n_pass++;
        n_checks++; if (DEST_ERR !== 1'b1) $display("FAIL t4_dest_err: got %0b want 1", DEST_ERR); else n_pass++;
        n_checks++; if (LEN_ERR !== 1'b0) $display("FAIL t4_len_ok: got %0b want 0", LEN_ERR); else n_pass++;
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        n_checks++; if (DEST_ERR !== 1'b0) $display("FAIL t4_dest_clr: got %0b want 0", DEST_ERR); else n_pass++;
        // Bad beat pushed; clear held during the cycle whose edge pops it.
        send_beat(32'd9, 1'b1, 4'd2);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        n_checks++; if (PKT_DONE !== 1'b1) $display("FAIL t4_pop_edge: got %0b want 1", PKT_DONE); else n_pass++;
        n_checks++; if (DEST_ERR !== 1'b1) $display("FAIL t4_set_wins: got %0b want 1", DEST_ERR); else n_pass++;
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        n_checks++; if (DEST_ERR !== 1'b0) $display("FAIL t4_dest_clr2: got %0b want 0", DEST_ERR); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic seen;
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(32'd10 + 32'(i), 1'b0, 4'd1);
        drain_en = 1'b1; tick(); drain_en = 1'b0;
        n_checks++; if (FIFO_LEVEL !== 3'd3) $display("FAIL t5_level_pre: got %0d want 3", FIFO_LEVEL); else n_pass++;
        RST_N = 1'b0;
        #1;
        n_checks++; if (FIFO_LEVEL !== 3'd0) $display("FAIL t5_level_rst: got %0d want 0", FIFO_LEVEL); else n_pass++;
        n_checks++;
        if ({PKT_COUNT, LAST_LEN, LAST_SUM} !== '0)
            $display("FAIL t5_counters_rst: got cnt=%0d len=%0d sum=%0d want 0", PKT_COUNT, LAST_LEN, LAST_SUM);
        else n_pass++;
        n_checks++; if (TREADY !== 1'b0) $display("FAIL t5_tready_rst: got %0b want 0", TREADY); else n_pass++;
        tick();
        RST_N = 1'b1;
        tick();
        n_checks++; if (TREADY !== 1'b1) $display("FAIL t5_tready_after: got %0b want 1", TREADY); else n_pass++;
        drain_en = 1'b1;
        send_beat(32'h33, 1'b1, 4'd1);
        wait_done(seen);
        n_checks++; if (seen !== 1'b1) $display("FAIL t5_done_timeout: got %0b want 1", seen); else n_pass++;
        n_checks++; if (LAST_LEN !== 16'd1) $display("FAIL t5_len: got %0d want 1", LAST_LEN); else n_pass++;
        n_checks++; if (LAST_SUM !== 40'h33) $display("FAIL t5_sum: got %0h want 33", LAST_SUM); else n_pass++;
        n_checks++; if (PKT_COUNT !== 16'd1) $display("FAIL t5_count: got %0d want 1", PKT_COUNT); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int     sent;
        logic   pend;
        logic   acc;
        logic   finished;
        longint sent_sum;
        longint rcv_sum;
        sent = 0; pend = 1'b0; sent_sum = 0; rcv_sum = 0; finished = 1'b0;
        drain_en = 1'b0; tdest = 4'd1;
        for (int c = 0; c < 3000; c++) begin
            if (!pend && sent < 1000) begin
                tdata = $urandom;
                tlast = (sent == 999) || ($urandom_range(0, 3) == 0);
                pend  = 1'b1;
            end
            tvalid = pend;
            if (c == 5) drain_en = 1'b1;
            acc = tvalid && TREADY;
            tick();
            if (acc) begin sent++; sent_sum += longint'(tdata); pend = 1'b0; end
            n_checks++;
            if (FIFO_LEVEL !== 3'(m_q.size())) $display("FAIL t6_level c=%0d: got %0d want %0d", c, FIFO_LEVEL, m_q.size()); else n_pass++;
            n_checks++;
            if (TREADY !== (m_q.size() != DEPTH)) $display("FAIL t6_tready c=%0d: got %0b want %0b", c, TREADY, m_q.size() != DEPTH); else n_pass++;
            n_checks++;
            if (PKT_DONE !== m_done) $display("FAIL t6_done c=%0d: got %0b want %0b", c, PKT_DONE, m_done); else n_pass++;
            if (c >= 5 && sent < 1000) begin
                n_checks++;
                if (FIFO_LEVEL < 3'd3 || FIFO_LEVEL > 3'd4) $display("FAIL t6_level_band c=%0d: got %0d want 3..4", c, FIFO_LEVEL); else n_pass++;
            end
            if (m_done) begin
                rcv_sum += longint'(LAST_SUM);
                n_checks++;
                if (LAST_SUM !== m_last_sum || LAST_LEN !== m_last_len || PKT_COUNT !== m_count)
                    $display("FAIL t6_pkt c=%0d: got sum=%0h len=%0d cnt=%0d want sum=%0h len=%0d cnt=%0d",
                             c, LAST_SUM, LAST_LEN, PKT_COUNT, m_last_sum, m_last_len, m_count);
                else n_pass++;
            end
            if (sent == 1000 && m_q.size() == 0 && FIFO_LEVEL == 3'd0) begin finished = 1'b1; break; end
        end
        tvalid = 1'b0;
        n_checks++; if (finished !== 1'b1) $display("FAIL t6_timeout: sent=%0d want 1000 and drained", sent); else n_pass++;
        n_checks++; if (rcv_sum !== sent_sum) $display("FAIL t6_total_sum: got %0d want %0d", rcv_sum, sent_sum); else n_pass++;
        n_checks++; if ({DEST_ERR, LEN_ERR} !== {m_derr, m_lerr}) $display("FAIL t6_errs: got %b want %b", {DEST_ERR, LEN_ERR}, {m_derr, m_lerr}); else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        RST_N = 1'b0; tvalid = 1'b0; tdata = '0; tlast = 1'b0; tid = '0;
        tdest = 4'd1; drain_en = 1'b0; clr_err = 1'b0;
        #1;
        test_reset();
        test_single();
        test_backpressure();
        test_len_err();
        test_dest_err();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
